fetch_unit: RTL

//  Instruction fetch stage feeding controlTable: holds the PC, fetches from instruction memory via req/ack,

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_unit_next_pc_calc.sv | 40 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and controlTable: FSM states, next-PC
// selector encodings and the opcode constants both sides decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_TRAP  = 2'd3
    } fetch_state_e;

    // pc_next_sel encodings; 2'b11 is reserved and behaves like PC_SEQ
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_JR   = 2'b10;

    // Opcodes (instr[31:26]); ALU ops use opcode 0 and are split by funct
    localparam logic [5:0] ALU  = 6'h00;
    localparam logic [5:0] J    = 6'h02;
    localparam logic [5:0] JAL  = 6'h03;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] BNE  = 6'h05;
    localparam logic [5:0] XORI = 6'h0E;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2B;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: sequential/branch, absolute jump or register jump.
// Latency: purely combinational. Backpressure: none, no state.
// Offsets and targets wrap modulo 2^PC_W; misalignment is handled by the caller.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [25:0]     instr_i,
    input  logic [1:0]      sel_i,
    input  logic            beq_i,
    input  logic            bne_i,
    input  logic            zero_i,
    input  logic [PC_W-1:0] rs_val_i,
    output logic [PC_W-1:0] npc_o
);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] jump_tgt;
    logic            taken;

    assign pc_plus4 = pc_i + PC_W'(4);

    // beq and bne together means either condition is enough to branch
    assign taken    = (beq_i & zero_i) | (bne_i & ~zero_i);
    assign br_off   = {{(PC_W-18){instr_i[15]}}, instr_i[15:0], 2'b00};
    assign jump_tgt = {pc_plus4[PC_W-1:28], instr_i[25:0], 2'b00};

    always_comb begin
        npc_o = pc_plus4;
        case (sel_i)
            PC_JUMP: npc_o = jump_tgt;
            PC_JR:   npc_o = rs_val_i;
            default: npc_o = taken ? (pc_plus4 + br_off) : pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one instruction in flight, fetch -> hold -> commit.
// Latency: >=1 cycle fetch after req, >=3 cycles/instr. Backpressure: holds instr until commit.
// Optional PC_MISALIGN_TRAP_EN: misaligned next PC traps instead of being aligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    input  logic            commit,
    input  logic [1:0]      pc_next_sel,
    input  logic            beq,
    input  logic            bne,
    input  logic            zero,
    input  logic [PC_W-1:0] rs_val,
    output logic            trap
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [PC_W-1:0] npc;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc_i     (pc_q),
        .instr_i  (instr_q[25:0]),
        .sel_i    (pc_next_sel),
        .beq_i    (beq),
        .bne_i    (bne),
        .zero_i   (zero),
        .rs_val_i (rs_val),
        .npc_o    (npc)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d        = trap_q;
`endif
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    instr_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    pc_d = npc;
                    if (npc[1:0] != 2'b00) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = npc & ALIGN_MASK;
                    state_d = S_FETCH;
`endif
                end
            end
            // S_TRAP is terminal until reset
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RESET;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= trap_d;
`endif
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_W'(4);

endmodule
